// File: rtl/lsu_sequencer_if.sv
// Core-side request/response and mem_interface-side signals of the load/store sequencer.
// The sequencer takes the slave modport; the core/memory side takes the master modport.
interface lsu_sequencer_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned SizeSize  = 2
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [AddrWidth-1:0] req_addr;
    logic [SizeSize:0]    req_funct3;
    logic [DataWidth-1:0] req_wdata;
    logic                 kill;

    logic                 resp_valid;
    logic                 resp_ready;
    logic [DataWidth-1:0] resp_rdata;
    logic [1:0]           resp_fault;

    logic [AddrWidth-1:0] mi_address;
    logic [SizeSize:0]    mi_sign_size;
    logic                 mi_rd;
    logic                 mi_wr;
    logic [DataWidth-1:0] mi_data_in;
    logic [DataWidth-1:0] mi_data_out;
    logic                 mi_complete_read;
    logic                 mi_complete_write;
    logic                 mi_malign_r;
    logic                 mi_hit_r;

    modport slave (
        input  req_valid, req_write, req_addr, req_funct3, req_wdata, kill, resp_ready,
               mi_data_out, mi_complete_read, mi_complete_write, mi_malign_r, mi_hit_r,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               mi_address, mi_sign_size, mi_rd, mi_wr, mi_data_in
    );

    modport master (
        output req_valid, req_write, req_addr, req_funct3, req_wdata, kill, resp_ready,
               mi_data_out, mi_complete_read, mi_complete_write, mi_malign_r, mi_hit_r,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               mi_address, mi_sign_size, mi_rd, mi_wr, mi_data_in
    );
endinterface

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: one request at a time, held toward mem_interface until granted.
// Optional grant-wait timeout (fault 3) is enabled by defining LSU_TIMEOUT_EN.
module lsu_sequencer #(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned SizeSize      = 2,
    parameter int unsigned TimeoutCycles = 64
) (
    input logic               clk_i,
    input logic               rst_i,
    lsu_sequencer_if.slave    lsu_io
);

    typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

    localparam logic [1:0] FaultNone    = 2'd0;
    localparam logic [1:0] FaultMalign  = 2'd1;
    localparam logic [1:0] FaultAccess  = 2'd2;
    localparam logic [1:0] FaultTimeout = 2'd3;

    state_e               state_q, state_d;
    logic                 write_q, write_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [SizeSize:0]    funct3_q, funct3_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic [1:0]           fault_q, fault_d;

    logic                 complete;
    logic                 timeout;

    logic                 req_ready;
    logic                 resp_valid;
    logic [AddrWidth-1:0] mi_address;
    logic [SizeSize:0]    mi_sign_size;
    logic                 mi_rd;
    logic                 mi_wr;
    logic [DataWidth-1:0] mi_data_in;

    assign complete = write_q ? lsu_io.mi_complete_write : lsu_io.mi_complete_read;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;

    // Counter is held at zero outside ISSUE, so it is clear on every entry.
    always_comb begin
        cnt_d   = '0;
        timeout = 1'b0;
        if (state_q == StIssue) begin
            cnt_d = cnt_q;
            if (!complete) begin
                cnt_d   = cnt_q + 1'b1;
                timeout = (cnt_d == CntWidth'(TimeoutCycles));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TimeoutCycles;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        fault_d      = fault_q;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mi_address   = '0;
        mi_sign_size = '0;
        mi_rd        = 1'b0;
        mi_wr        = 1'b0;
        mi_data_in   = '0;

        if (state_q != StIdle) begin
            mi_address   = addr_q;
            mi_sign_size = funct3_q;
            mi_data_in   = wdata_q;
        end

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (lsu_io.req_valid && !lsu_io.kill) begin
                    write_d  = lsu_io.req_write;
                    addr_d   = lsu_io.req_addr;
                    funct3_d = lsu_io.req_funct3;
                    wdata_d  = lsu_io.req_wdata;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                mi_rd = !write_q;
                mi_wr = write_q;
                // A granted store may already be committed, so grant beats kill.
                if (complete) begin
                    state_d = StCapture;
                end else if (lsu_io.kill) begin
                    state_d = StIdle;
                end else if (timeout) begin
                    fault_d = FaultTimeout;
                    rdata_d = '0;
                    state_d = StResp;
                end
            end
            StCapture: begin
                if (lsu_io.mi_malign_r) begin
                    fault_d = FaultMalign;
                    rdata_d = '0;
                end else if (!lsu_io.mi_hit_r) begin
                    fault_d = FaultAccess;
                    rdata_d = '0;
                end else begin
                    fault_d = FaultNone;
                    rdata_d = write_q ? '0 : lsu_io.mi_data_out;
                end
                state_d = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                if (lsu_io.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            write_q  <= 1'b0;
            addr_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= FaultNone;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    assign lsu_io.req_ready    = req_ready;
    assign lsu_io.resp_valid   = resp_valid;
    assign lsu_io.resp_rdata   = rdata_q;
    assign lsu_io.resp_fault   = fault_q;
    assign lsu_io.mi_address   = mi_address;
    assign lsu_io.mi_sign_size = mi_sign_size;
    assign lsu_io.mi_rd        = mi_rd;
    assign lsu_io.mi_wr        = mi_wr;
    assign lsu_io.mi_data_in   = mi_data_in;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Scoreboard bench for lsu_sequencer with a small byte-addressed mem_interface model.
// Define LSU_TIMEOUT_EN to also exercise the grant-wait timeout (TimeoutCycles = 8).
module tb_lsu_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_sequencer_if #(.DataWidth(32), .AddrWidth(32), .SizeSize(2)) bus ();

    lsu_sequencer #(
        .DataWidth     (32),
        .AddrWidth     (32),
        .SizeSize      (2),
        .TimeoutCycles (8)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .lsu_io (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- mem_interface model ----------------
    logic [7:0]  mem [0:4095];
    int unsigned wait_cnt    = 0;
    int unsigned grant_delay = 0;
    bit          never_grant = 1'b0;
    logic        busy, grant;

    assign busy  = bus.mi_rd | bus.mi_wr;
    assign grant = busy && !never_grant && (wait_cnt == grant_delay);
    assign bus.mi_complete_read  = grant && bus.mi_rd;
    assign bus.mi_complete_write = grant && bus.mi_wr;

    function automatic logic is_malign(input logic [31:0] a, input logic [2:0] ss);
        return (ss[1:0] == 2'd1 && a[0]) || (ss[1:0] == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic is_hit(input logic [31:0] a);
        return a < 32'h1000;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] a, input logic [2:0] ss);
        logic [11:0] i;
        logic [7:0]  b;
        logic [15:0] h;
        i = a[11:0];
        b = mem[i];
        h = {mem[i+12'd1], mem[i]};
        case (ss[1:0])
            2'd0:    return ss[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'd1:    return ss[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: return {mem[i+12'd3], mem[i+12'd2], h};
        endcase
    endfunction

    always @(posedge clk) begin
        if (grant) begin
            wait_cnt        <= 0;
            bus.mi_malign_r <= is_malign(bus.mi_address, bus.mi_sign_size);
            bus.mi_hit_r    <= is_hit(bus.mi_address);
            if (bus.mi_rd) begin
                bus.mi_data_out <= (is_malign(bus.mi_address, bus.mi_sign_size) ||
                                    !is_hit(bus.mi_address)) ? 32'd0 :
                                   load_val(bus.mi_address, bus.mi_sign_size);
            end
            if (bus.mi_wr && !is_malign(bus.mi_address, bus.mi_sign_size) &&
                is_hit(bus.mi_address)) begin
                mem[bus.mi_address[11:0]] <= bus.mi_data_in[7:0];
                if (bus.mi_sign_size[1:0] != 2'd0)
                    mem[bus.mi_address[11:0]+12'd1] <= bus.mi_data_in[15:8];
                if (bus.mi_sign_size[1:0] == 2'd2) begin
                    mem[bus.mi_address[11:0]+12'd2] <= bus.mi_data_in[23:16];
                    mem[bus.mi_address[11:0]+12'd3] <= bus.mi_data_in[31:24];
                end
            end
        end else if (busy) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    // ---------------- scoreboard ----------------
    logic [33:0] exp_q [$];

    always @(negedge clk) begin
        if (!rst && bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 1, 0);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                check("resp_rdata", bus.resp_rdata, e[31:0]);
                check("resp_fault", bus.resp_fault, e[33:32]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                             input logic [31:0] wd);
        bit seen;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_addr   = addr;
        bus.req_funct3 = f3;
        bus.req_wdata  = wd;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check("req_accept", seen, 1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic [1:0] exp_f, input int unsigned gd);
        int lat;
        grant_delay = gd;
        exp_q.push_back({exp_f, exp_rd});
        drive_req(wr, addr, f3, wd);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid) break;
        end
        check("resp_latency", lat, 3 + gd);
        wait_drain();
    endtask

    initial begin
        int n;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_funct3 = '0;
        bus.req_wdata  = '0;
        bus.kill       = 1'b0;
        bus.resp_ready = 1'b1;
        bus.mi_data_out = '0;
        bus.mi_malign_r = 1'b0;
        bus.mi_hit_r    = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_resp_fault", bus.resp_fault, 0);
        check("rst_mi_rdwr", {bus.mi_rd, bus.mi_wr}, 0);
        check("rst_mi_addr", bus.mi_address, 0);
        @(posedge clk);
        #1;

        do_req(1'b1, 32'h100, 3'b010, 32'hDEADBEEF, 32'h0, 2'd0, 0);        // SW
        do_req(1'b0, 32'h100, 3'b010, 32'h0, 32'hDEADBEEF, 2'd0, 0);        // LW
        do_req(1'b1, 32'h103, 3'b000, 32'h80, 32'h0, 2'd0, 0);              // SB
        do_req(1'b0, 32'h103, 3'b000, 32'h0, 32'hFFFFFF80, 2'd0, 0);        // LB
        do_req(1'b0, 32'h103, 3'b100, 32'h0, 32'h00000080, 2'd0, 0);        // LBU
        do_req(1'b1, 32'h101, 3'b001, 32'hFFFF, 32'h0, 2'd1, 0);            // SH misaligned
        do_req(1'b0, 32'h100, 3'b010, 32'h0, 32'h80ADBEEF, 2'd0, 0);        // SH left memory alone
        do_req(1'b0, 32'h2000, 3'b010, 32'h0, 32'h0, 2'd2, 0);              // no hit
        do_req(1'b0, 32'h102, 3'b001, 32'h0, 32'hFFFF80AD, 2'd0, 0);        // LH
        do_req(1'b0, 32'h102, 3'b101, 32'h0, 32'h000080AD, 2'd0, 0);        // LHU
        do_req(1'b0, 32'h101, 3'b010, 32'h0, 32'h0, 2'd1, 0);               // LW misaligned
        do_req(1'b0, 32'h100, 3'b010, 32'h0, 32'h80ADBEEF, 2'd0, 2);        // delayed grant

        // Kill during third ISSUE cycle of a 5-cycle-delayed grant: no response.
        grant_delay = 5;
        drive_req(1'b0, 32'h100, 3'b010, 32'h0);
        @(negedge clk);
        check("issue_mi_rd", bus.mi_rd, 1);
        check("issue_mi_addr", bus.mi_address, 32'h100);
        check("issue_mi_size", bus.mi_sign_size, 3'b010);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 bus.kill = 1'b1;
        @(posedge clk);
        #1 bus.kill = 1'b0;
        @(negedge clk);
        check("kill_req_ready", bus.req_ready, 1);
        check("kill_mi_rd", bus.mi_rd, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.resp_valid) n++;
        end
        check("kill_no_resp", n, 0);
        @(posedge clk);
        #1;

        // Kill coincident with grant: response still delivered.
        exp_q.push_back({2'd0, 32'h80ADBEEF});
        drive_req(1'b0, 32'h100, 3'b010, 32'h0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mi_complete_read) begin
                n = 1;
                break;
            end
        end
        check("kill_grant_seen", n, 1);
        bus.kill = 1'b1;
        @(posedge clk);
        #1 bus.kill = 1'b0;
        wait_drain();

        // Response back-pressure.
        grant_delay    = 0;
        bus.resp_ready = 1'b0;
        exp_q.push_back({2'd0, 32'hDEADBEEF});
        do_req_bp: begin
            drive_req(1'b1, 32'h100, 3'b010, 32'hDEADBEEF);
            exp_q.pop_front();
            exp_q.push_back({2'd0, 32'h0});
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.resp_valid) break;
            end
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("bp_resp_valid", bus.resp_valid, 1);
                check("bp_resp_rdata", bus.resp_rdata, 0);
                check("bp_req_ready", bus.req_ready, 0);
            end
            @(posedge clk);
            #1 bus.resp_ready = 1'b1;
            wait_drain();
        end
        do_req(1'b0, 32'h100, 3'b010, 32'h0, 32'hDEADBEEF, 2'd0, 0);

        // Reset mid-transaction abandons it.
        grant_delay = 5;
        drive_req(1'b0, 32'h100, 3'b010, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_req_ready", bus.req_ready, 1);
        check("rst_mid_mi_rd", bus.mi_rd, 0);
        check("rst_mid_resp_valid", bus.resp_valid, 0);
        @(posedge clk);
        #1;

`ifdef LSU_TIMEOUT_EN
        // Grant never given: 8 ISSUE cycles, then fault 3 with mi_rd low.
        never_grant = 1'b1;
        exp_q.push_back({2'd3, 32'h0});
        drive_req(1'b0, 32'h100, 3'b010, 32'h0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.mi_rd) break;
            n++;
        end
        check("to_issue_cycles", n, 8);
        check("to_resp_valid", bus.resp_valid, 1);
        wait_drain();
        never_grant = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
